// File: rtl/mem_copy_engine.sv
// Byte-serial memory copy/fill engine: copy reads each source byte then writes it,
// fill writes fill_value; transfers run in ascending address order with pointer wrap.
module mem_copy_engine #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [7:0]    len,
  input  logic [7:0]    fill_value,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] DataAddress,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [7:0]    DataIn,
  input  logic [7:0]    DataOut
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state, next_state;
  logic [AW-1:0] src_ptr, dst_ptr;
  logic [7:0]    count;
  logic          mode_r;
  logic [7:0]    fill_r;
  logic [7:0]    buffer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      mode_r  <= 1'b0;
      fill_r  <= '0;
      buffer  <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src_base;
            dst_ptr <= dst_base;
            count   <= len;
            mode_r  <= mode;
            fill_r  <= fill_value;
          end
        end
        READ: buffer <= DataOut;
        WRITE: begin
          src_ptr <= src_ptr + 1'b1;
          dst_ptr <= dst_ptr + 1'b1;
          count   <= count - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == 8'd0)  next_state = DONE;
          else if (mode)    next_state = WRITE;
          else              next_state = READ;
        end
      end
      READ:  next_state = WRITE;
      WRITE: begin
        if (count == 8'd1) next_state = DONE;
        else if (mode_r)   next_state = WRITE;
        else               next_state = READ;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Memory strobes are masked by reset so an aborted transfer never commits
  // the byte of the cycle in which reset is sampled.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    DataAddress = '0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataIn      = '0;
    case (state)
      READ: begin
        busy        = 1'b1;
        DataAddress = src_ptr;
        ReadMem     = !reset;
      end
      WRITE: begin
        busy        = 1'b1;
        DataAddress = dst_ptr;
        WriteMem    = !reset;
        DataIn      = mode_r ? fill_r : buffer;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a byte-array memory model plus a
// reference memory updated by plain ascending copy/fill loops.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       reset, start, mode;
  logic [7:0] src_base, dst_base, len, fill_value;
  logic       busy, done, ReadMem, WriteMem;
  logic [7:0] DataAddress, DataIn, DataOut;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       load_en;
  logic [7:0] load_addr, load_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rd_addrs [$];

  always #5 clk = ~clk;

  mem_copy_engine #(.AW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .len(len), .fill_value(fill_value),
    .busy(busy), .done(done), .DataAddress(DataAddress), .ReadMem(ReadMem),
    .WriteMem(WriteMem), .DataIn(DataIn), .DataOut(DataOut)
  );

  assign DataOut = mem[DataAddress];

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (WriteMem) mem[DataAddress] <= DataIn;
  end

  task automatic load_byte(input logic [7:0] a, input logic [7:0] v);
    load_en = 1'b1; load_addr = a; load_data = v;
    @(negedge clk);
    load_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int l);
    for (int i = 0; i < l; i++) ref_mem[8'(d + 8'(i))] = ref_mem[8'(s + 8'(i))];
  endtask

  task automatic model_fill(input logic [7:0] d, input int l, input logic [7:0] f);
    for (int i = 0; i < l; i++) ref_mem[8'(d + 8'(i))] = f;
  endtask

  function automatic int first_diff();
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) return i;
    return -1;
  endfunction

  // Starts one transfer, scrambles the inputs afterwards, and observes until done.
  task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] f, input int budget,
                          input bit poke_start, output int busy_cyc, output int done_cnt,
                          output int done_at, output int nrw);
    start = 1'b1; mode = m; src_base = s; dst_base = d; len = l; fill_value = f;
    @(negedge clk);
    start = 1'b0;
    mode = 1'($urandom); src_base = 8'($urandom); dst_base = 8'($urandom);
    len = 8'($urandom); fill_value = 8'($urandom);
    rd_addrs.delete();
    busy_cyc = 0; done_cnt = 0; done_at = -1; nrw = 0;
    for (int i = 1; i <= budget; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (ReadMem) rd_addrs.push_back(DataAddress);
      if (ReadMem || WriteMem) nrw++;
      if (done_at > 0 && i >= done_at + 3) break;
      start = poke_start && (i == 2 || i == 5);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; src_base = '0; dst_base = '0;
    len = '0; fill_value = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, ReadMem, WriteMem, DataAddress, DataIn} !== 20'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {busy, done, ReadMem, WriteMem, DataAddress, DataIn});
    end
    start = 1'b1; len = 8'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_over_start: busy,done=%b want 00", {busy, done});
    end
  endtask

  task automatic init_memory();
    for (int i = 0; i < 256; i++) load_byte(8'(i), 8'($urandom));
  endtask

  task automatic test_copy_basic();
    int bc, dc, da, nrw, fd;
    load_byte(8'h10, 8'h11); load_byte(8'h11, 8'h22);
    load_byte(8'h12, 8'h33); load_byte(8'h13, 8'h44);
    model_copy(8'h10, 8'h80, 4);
    run_xfer(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 30, 1'b0, bc, dc, da, nrw);
    n_cmp++; if (bc !== 8) begin n_bad++; $display("FAIL copy_busy: got %0d want 8", bc); end
    n_cmp++; if (da !== 9) begin n_bad++; $display("FAIL copy_done_cycle: got %0d want 9", da); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL copy_done_count: got %0d want 1", dc); end
    fd = first_diff();
    n_cmp++;
    if (fd !== -1) begin
      n_bad++;
      $display("FAIL copy_mem: addr %h got %h want %h", fd, mem[fd], ref_mem[fd]);
    end
  endtask

  task automatic test_fill();
    int bc, dc, da, nrw, fd;
    load_byte(8'h43, 8'h5E);
    model_fill(8'h40, 3, 8'hA5);
    run_xfer(1'b1, 8'h00, 8'h40, 8'd3, 8'hA5, 20, 1'b0, bc, dc, da, nrw);
    n_cmp++; if (bc !== 3) begin n_bad++; $display("FAIL fill_busy: got %0d want 3", bc); end
    n_cmp++; if (da !== 4) begin n_bad++; $display("FAIL fill_done_cycle: got %0d want 4", da); end
    n_cmp++; if (nrw !== 3) begin n_bad++; $display("FAIL fill_accesses: got %0d want 3", nrw); end
    fd = first_diff();
    n_cmp++;
    if (fd !== -1) begin
      n_bad++;
      $display("FAIL fill_mem: addr %h got %h want %h", fd, mem[fd], ref_mem[fd]);
    end
  endtask

  task automatic test_zero_len();
    int bc, dc, da, nrw;
    run_xfer(1'b0, 8'h20, 8'h30, 8'd0, 8'h77, 10, 1'b0, bc, dc, da, nrw);
    n_cmp++; if (da !== 1) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 1", da); end
    n_cmp++; if (nrw !== 0) begin n_bad++; $display("FAIL zero_accesses: got %0d want 0", nrw); end
    n_cmp++; if (bc !== 0) begin n_bad++; $display("FAIL zero_busy: got %0d want 0", bc); end
  endtask

  task automatic test_wrap();
    int bc, dc, da, nrw, fd;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'hFE; exp_rd[1] = 8'hFF; exp_rd[2] = 8'h00; exp_rd[3] = 8'h01;
    model_copy(8'hFE, 8'h02, 4);
    run_xfer(1'b0, 8'hFE, 8'h02, 8'd4, 8'h00, 30, 1'b0, bc, dc, da, nrw);
    n_cmp++;
    if (rd_addrs.size() !== 4) begin
      n_bad++;
      $display("FAIL wrap_read_count: got %0d want 4", rd_addrs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (rd_addrs[i] !== exp_rd[i]) begin
          n_bad++;
          $display("FAIL wrap_read_addr[%0d]: got %h want %h", i, rd_addrs[i], exp_rd[i]);
        end
      end
    end
    fd = first_diff();
    n_cmp++;
    if (fd !== -1) begin
      n_bad++;
      $display("FAIL wrap_mem: addr %h got %h want %h", fd, mem[fd], ref_mem[fd]);
    end
  endtask

  task automatic test_reset_mid();
    int dcnt, fd;
    dcnt = 0;
    model_fill(8'h50, 3, 8'h3C);
    start = 1'b1; mode = 1'b1; dst_base = 8'h50; len = 8'd10; fill_value = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    n_cmp++;
    if ({busy, WriteMem, DataAddress} !== {2'b11, 8'h53}) begin
      n_bad++;
      $display("FAIL mid_fourth_write: got %h want %h", {busy, WriteMem, DataAddress}, {2'b11, 8'h53});
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, ReadMem, WriteMem, DataAddress, DataIn} !== 20'b0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h want 0", {busy, done, ReadMem, WriteMem, DataAddress, DataIn});
    end
    reset = 1'b0;
    repeat (5) begin
      if (done || WriteMem) dcnt++;
      @(negedge clk);
    end
    n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d want 0", dcnt); end
    fd = first_diff();
    n_cmp++;
    if (fd !== -1) begin
      n_bad++;
      $display("FAIL mid_mem: addr %h got %h want %h", fd, mem[fd], ref_mem[fd]);
    end
  endtask

  task automatic test_start_busy();
    int bc, dc, da, nrw, fd;
    model_copy(8'h60, 8'h90, 6);
    run_xfer(1'b0, 8'h60, 8'h90, 8'd6, 8'h00, 40, 1'b1, bc, dc, da, nrw);
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL busy_start_done_count: got %0d want 1", dc); end
    n_cmp++; if (bc !== 12) begin n_bad++; $display("FAIL busy_start_busy: got %0d want 12", bc); end
    fd = first_diff();
    n_cmp++;
    if (fd !== -1) begin
      n_bad++;
      $display("FAIL busy_start_mem: addr %h got %h want %h", fd, mem[fd], ref_mem[fd]);
    end
  endtask

  task automatic test_random();
    int bc, dc, da, nrw, fd, l, exp_busy;
    logic m;
    logic [7:0] s, d, f;
    for (int t = 0; t < 21; t++) begin
      m = 1'($urandom); s = 8'($urandom); d = 8'($urandom); f = 8'($urandom);
      l = (t == 20) ? 255 : int'($urandom_range(0, 40));
      if (m) model_fill(d, l, f);
      else   model_copy(s, d, l);
      exp_busy = m ? l : 2 * l;
      run_xfer(m, s, d, 8'(l), f, 2 * l + 10, 1'b0, bc, dc, da, nrw);
      n_cmp++;
      if (bc !== exp_busy || da !== exp_busy + 1 || dc !== 1) begin
        n_bad++;
        $display("FAIL rand_timing[%0d]: busy=%0d done_at=%0d pulses=%0d want %0d/%0d/1",
                 t, bc, da, dc, exp_busy, exp_busy + 1);
      end
      n_cmp++;
      if (nrw !== exp_busy) begin
        n_bad++;
        $display("FAIL rand_accesses[%0d]: got %0d want %0d", t, nrw, exp_busy);
      end
      fd = first_diff();
      n_cmp++;
      if (fd !== -1) begin
        n_bad++;
        $display("FAIL rand_mem[%0d]: addr %h got %h want %h", t, fd, mem[fd], ref_mem[fd]);
      end
    end
  endtask

  initial begin
    test_reset();
    init_memory();
    test_copy_basic();
    test_fill();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
